// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button reader: FSM state encoding
// and the millisecond-to-cycle conversion used to size its counters.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    LONG_HELD,
    RELEASE_WAIT
  } btn_state_t;

  // Integer ms -> clock cycles; divide first so large clocks stay in range.
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs; both flops reset to
// RST_VAL so the idle level is presented immediately after reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_reader.sv
// Push-button reader: synchronises and debounces one pad, then emits
// single-cycle press / release / short / long events and a clean level.
module button_reader
  import button_pkg::*;
#(
  parameter int CLK_HZ      = 25000000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output btn_state_t state_dbg
);

  localparam int DEB_CYC  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int CNT_W    = $clog2(LONG_CYC + 1);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

  generate
    if (DEB_CYC < 1 || LONG_CYC <= DEB_CYC) begin : g_bad_timing
      $error("button_reader: need DEB_CYC >= 1 and LONG_CYC > DEB_CYC");
    end
  endgenerate

  // Valid/ready does not apply here: every *_pulse output is a one-cycle
  // strobe with no back-pressure; consumers must sample it on the cycle it is high.

  logic sync_q;
  logic p;

  sync_2ff #(.RST_VAL(ACTIVE_LOW != 0)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (sync_q)
  );

  assign p = (ACTIVE_LOW != 0) ? ~sync_q : sync_q;

  btn_state_t       state, state_n;
  logic [CNT_W-1:0] deb_cnt, deb_n;
  logic [CNT_W-1:0] long_cnt, long_n;
  logic             long_fired, fired_n;
  logic             level_n, press_n, release_n, short_n, long_p_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      long_cnt      <= '0;
      long_fired    <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_n;
      deb_cnt       <= deb_n;
      long_cnt      <= long_n;
      long_fired    <= fired_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      short_pulse   <= short_n;
      long_pulse    <= long_p_n;
    end
  end

  always_comb begin
    state_n   = state;
    deb_n     = deb_cnt;
    long_n    = long_cnt;
    fired_n   = long_fired;
    level_n   = btn_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    short_n   = 1'b0;
    long_p_n  = 1'b0;
    case (state)
      IDLE: begin
        if (p) begin
          state_n = PRESS_WAIT;
          deb_n   = ONE;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_n = IDLE;
          deb_n   = '0;
        end else if (deb_cnt >= DEB_LAST) begin
          state_n = HELD;
          press_n = 1'b1;
          level_n = 1'b1;
          long_n  = '0;
          fired_n = 1'b0;
          deb_n   = '0;
        end else if (deb_cnt != CNT_MAX) begin
          deb_n = deb_cnt + ONE;
        end
      end
      HELD: begin
        // long_cnt only advances while held, so bounces freeze it in place.
        if (!p) begin
          state_n = RELEASE_WAIT;
          deb_n   = ONE;
        end else if (long_cnt >= LONG_LAST) begin
          state_n  = LONG_HELD;
          long_p_n = 1'b1;
          fired_n  = 1'b1;
        end else begin
          long_n = long_cnt + ONE;
        end
      end
      LONG_HELD: begin
        if (!p) begin
          state_n = RELEASE_WAIT;
          deb_n   = ONE;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_n = long_fired ? LONG_HELD : HELD;
          deb_n   = '0;
        end else if (deb_cnt >= DEB_LAST) begin
          state_n   = IDLE;
          release_n = 1'b1;
          short_n   = ~long_fired;
          level_n   = 1'b0;
          deb_n     = '0;
        end else if (deb_cnt != CNT_MAX) begin
          deb_n = deb_cnt + ONE;
        end
      end
      default: begin
        state_n = IDLE;
        deb_n   = '0;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: directed scenarios plus random press streams,
// compared every cycle against a sample-history reference model.
module tb_button_reader;
  import button_pkg::*;

  localparam int CLK_HZ      = 1000;
  localparam int DEBOUNCE_MS = 4;
  localparam int LONG_MS     = 20;
  localparam int ACTIVE_LOW  = 1;
  localparam int DEB_CYC     = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYC    = CLK_HZ / 1000 * LONG_MS;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic btn_level, press_pulse, release_pulse, short_pulse, long_pulse;
  btn_state_t state_dbg;

  always #5 clk = ~clk;

  button_reader #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .LONG_MS     (LONG_MS),
    .ACTIVE_LOW  (ACTIVE_LOW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse),
    .state_dbg     (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: pressed samples seen through a 2-sample delay, a window
  // of the last DEB_CYC samples, and a count of uninterrupted held samples
  bit dq[$];
  bit ph[$];
  bit m_level, m_press, m_release, m_short, m_long, m_fired, m_last_p;
  int m_hold;

  // scenario marks taken from observed pulses
  int t0, press_at, long_at, release_at;
  int n_press, n_long, n_release, n_short;

  function automatic void model_reset();
    dq = '{1'b0, 1'b0};
    ph.delete();
    m_level = 0; m_press = 0; m_release = 0; m_short = 0; m_long = 0;
    m_fired = 0; m_last_p = 0; m_hold = 0;
  endfunction

  function automatic void model_step(input bit b);
    bit pr, p, all_diff;
    pr = (ACTIVE_LOW != 0) ? !b : b;
    dq.push_back(pr);
    p = dq.pop_front();
    m_press = 0; m_release = 0; m_short = 0; m_long = 0;
    if (m_level && p && m_last_p && !m_fired) begin
      m_hold++;
      if (m_hold == LONG_CYC) begin
        m_long  = 1;
        m_fired = 1;
      end
    end
    ph.push_back(p);
    if (ph.size() > DEB_CYC) void'(ph.pop_front());
    all_diff = (ph.size() == DEB_CYC);
    foreach (ph[i]) if (ph[i] == m_level) all_diff = 0;
    if (all_diff) begin
      m_level = !m_level;
      if (m_level) begin
        m_press = 1; m_hold = 0; m_fired = 0;
      end else begin
        m_release = 1; m_short = !m_fired;
      end
    end
    m_last_p = p;
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("btn_level", 32'(btn_level), 32'(m_level));
    chk("press_pulse", 32'(press_pulse), 32'(m_press));
    chk("release_pulse", 32'(release_pulse), 32'(m_release));
    chk("short_pulse", 32'(short_pulse), 32'(m_short));
    chk("long_pulse", 32'(long_pulse), 32'(m_long));
    chk("pulse_exclusive", 32'($onehot0({press_pulse, long_pulse, release_pulse})), 32'd1);
    chk("short_needs_release", 32'(short_pulse && !release_pulse), 32'd0);
    if (press_pulse === 1'b1) begin press_at = cyc; n_press++; end
    if (long_pulse === 1'b1) begin long_at = cyc; n_long++; end
    if (release_pulse === 1'b1) begin release_at = cyc; n_release++; end
    if (short_pulse === 1'b1) n_short++;
  endtask

  // drivers
  task automatic step(input bit b);
    btn_in = b;
    @(posedge clk);
    cyc++;
    if (rst_n) model_step(b);
    else model_reset();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input bit b, input int n);
    repeat (n) step(b);
  endtask

  task automatic mark();
    t0 = cyc;
    press_at = -1; long_at = -1; release_at = -1;
    n_press = 0; n_long = 0; n_release = 0; n_short = 0;
  endtask

  int t1;
  bit rb;

  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b1;
    model_reset();
    mark();
    repeat (2) @(negedge clk);

    // reset held with a toggling pin
    for (int i = 0; i < 8; i++) begin
      step(1'($urandom_range(0, 1)));
      chk("rst_state", 32'(state_dbg), 32'(IDLE));
    end
    rst_n = 1'b1;
    mark();
    run(1'b1, 12);
    chk("post_reset_pulses", n_press + n_release + n_long, 0);

    // glitch shorter than the debounce window
    mark();
    run(1'b0, 3);
    run(1'b1, 12);
    chk("glitch_press", n_press, 0);
    chk("glitch_level", 32'(btn_level), 32'd0);

    // short press
    mark();
    run(1'b0, 10);
    chk("short_press_at", press_at - t0, 6);
    t1 = cyc;
    run(1'b1, 10);
    chk("short_release_at", release_at - t1, 6);
    chk("short_short_cnt", n_short, 1);
    chk("short_long_cnt", n_long, 0);

    // long press
    mark();
    run(1'b0, 40);
    chk("long_press_at", press_at - t0, 6);
    chk("long_long_at", long_at - t0, 26);
    t1 = cyc;
    run(1'b1, 10);
    chk("long_release_at", release_at - t1, 6);
    chk("long_release_cnt", n_release, 1);
    chk("long_short_cnt", n_short, 0);

    // bounce during hold freezes the long timer
    mark();
    run(1'b0, 18);
    run(1'b1, 2);
    run(1'b0, 40);
    chk("bounce_release_cnt", n_release, 0);
    chk("bounce_press_cnt", n_press, 1);
    chk("bounce_long_at", long_at - t0, 29);
    chk("bounce_long_cnt", n_long, 1);
    run(1'b1, 10);
    chk("bounce_short_cnt", n_short, 0);

    // reset while a press is being debounced
    mark();
    run(1'b0, 3);
    chk("pw_state", 32'(state_dbg), 32'(PRESS_WAIT));
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("midrst_state", 32'(state_dbg), 32'(IDLE));
    run(1'b0, 2);
    rst_n = 1'b1;
    mark();
    run(1'b0, 10);
    chk("midrst_press_at", press_at - t0, 6);
    chk("midrst_press_cnt", n_press, 1);
    run(1'b1, 12);

    // random press/release segments, model-checked each cycle
    rb = 1'b1;
    for (int s = 0; s < 40; s++) begin
      rb = !rb;
      run(rb, $urandom_range(1, 30));
    end
    run(1'b1, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_reader.md
Name: button_reader

Overview:
- Input-side counterpart to the LED drivers on the Colorlight i9+ board: reads one raw push-button pin and turns it into clean, single-cycle event pulses for the fabric.
- Synchronises the pin, debounces it with a cycle counter and classifies each press as short or long.
- Sits directly behind a top-level button pad. Its pulses feed mode, toggle and blink-control logic.

Parameters:
- CLK_HZ, 25000000: clock frequency in Hz.
- DEBOUNCE_MS, 10: time the input must stay stable before a level change is accepted.
- LONG_MS, 1000: hold time, measured from press_pulse, at which a press counts as long.
- ACTIVE_LOW, 1: 1 = pin reads 0 when the button is pressed; 0 = pin reads 1 when pressed.

Ports:
- clk  input  1  system clock, CLK_HZ.
- rst_n  input  1  asynchronous, active-low reset.
- btn_in  input  1  raw, asynchronous button pin.
- btn_level  output  1  debounced level, 1 = pressed.
- press_pulse  output  1  one-cycle pulse when a press is accepted.
- release_pulse  output  1  one-cycle pulse when a release is accepted.
- short_pulse  output  1  one-cycle pulse, coincident with release_pulse, when the press did not reach long.
- long_pulse  output  1  one-cycle pulse when the hold reaches LONG_MS, while the button is still held.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- All outputs are registered and reset to 0. State resets to IDLE, counters to 0, long_fired to 0.
- Synchroniser flops reset to the released level: 1 if ACTIVE_LOW, else 0.
- Derived cycle counts (localparams):
  - DEB_CYC = CLK_HZ/1000*DEBOUNCE_MS
  - LONG_CYC = CLK_HZ/1000*LONG_MS
  - Requires DEB_CYC >= 1 and LONG_CYC > DEB_CYC; enforce with an elaboration-time check.
- Counter widths are $clog2(LONG_CYC+1). Counters saturate and never wrap.
- Input path: btn_in goes through a 2-FF synchroniser, then is normalised so that p = 1 means pressed.
- FSM states: IDLE, PRESS_WAIT, HELD, LONG_HELD, RELEASE_WAIT.
- IDLE:
  - p = 1: go to PRESS_WAIT, deb_cnt = 1.
- PRESS_WAIT:
  - p = 0: back to IDLE, deb_cnt = 0. No pulse is emitted (glitch rejected).
  - p = 1 and deb_cnt = DEB_CYC-1: go to HELD; press_pulse = 1 next cycle; btn_level = 1; long_cnt = 0; long_fired = 0.
  - otherwise: deb_cnt increments.
- HELD:
  - long_cnt increments each cycle.
  - long_cnt = LONG_CYC-1 with p = 1: go to LONG_HELD; long_pulse = 1; long_fired = 1.
  - p = 0: go to RELEASE_WAIT, deb_cnt = 1. long_cnt is frozen, not cleared.
- LONG_HELD:
  - p = 0: go to RELEASE_WAIT, deb_cnt = 1.
- RELEASE_WAIT:
  - p = 1 (bounce): return to HELD if long_fired = 0, else LONG_HELD. deb_cnt = 0; long_cnt resumes from its frozen value. No pulse is emitted.
  - p = 0 and deb_cnt = DEB_CYC-1: go to IDLE; release_pulse = 1; short_pulse = !long_fired; btn_level = 0.
- Latency:
  - press_pulse is asserted exactly 2+DEB_CYC cycles after btn_in was first sampled pressed, for a clean edge.
  - release_pulse follows the same rule for release.
  - long_pulse is asserted exactly LONG_CYC cycles after press_pulse, if no bounce occurs.
- Pulse exclusivity: at most one of press_pulse, long_pulse and release_pulse is high in any cycle. short_pulse is only ever high together with release_pulse.
- Reset mid-operation: returns immediately to IDLE with all outputs 0. Any pending press or release is discarded and no pulse is emitted for it.

Decomposition:
- button_pkg holds:
  - the state typedef, btn_state_t, an enum of the five states;
  - a function ms_to_cycles(clk_hz, ms).
- One sub-module, sync_2ff:
  - a 2-flop synchroniser with a reset-value parameter;
  - reusable for the other pad inputs.

Test Plan:
- Run all scenarios with CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=20, ACTIVE_LOW=1, giving DEB_CYC=4 and LONG_CYC=20.
- Reset check: hold rst_n=0 with btn_in toggling randomly -> all outputs stay 0. Release rst_n with btn_in=1 -> no pulses.
- Glitch rejection: drive btn_in low for 3 cycles, then high -> no pulses, btn_level stays 0.
- Short press: btn_in low for 10 cycles, then high:
  - press_pulse at cycle 6 after the falling edge;
  - release_pulse and short_pulse together at cycle 6 after the rising edge;
  - long_pulse never asserts.
- Long press: btn_in low for 40 cycles:
  - press_pulse at cycle 6;
  - long_pulse at cycle 26;
  - on release: release_pulse = 1 and short_pulse = 0.
- Bouncy release: during a hold, pulse btn_in high for 2 cycles at hold cycle 12 -> no release_pulse; long_pulse is delayed by the frozen cycles and still fires once.
- Reset mid-press: pull rst_n low during PRESS_WAIT, then release it with btn_in still low -> the press is re-detected from scratch, with press_pulse 6 cycles after rst_n rises.
